// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one synchronous memory port (IDLE/ISSUE/WAIT).
// Optional ownership locking is enabled by defining ARB_LOCK_EN.
module mem_arbiter #(
  parameter int width    = 32,
  parameter int addrsize = 8,
  parameter int max_lock = 4
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                req_0,
  input  logic                req_1,
  input  logic                we_0,
  input  logic                we_1,
  input  logic [addrsize-1:0] addr_0,
  input  logic [addrsize-1:0] addr_1,
  input  logic [width-1:0]    wdata_0,
  input  logic [width-1:0]    wdata_1,
  input  logic                lock_0,
  input  logic                lock_1,
  output logic                gnt_0,
  output logic                gnt_1,
  output logic                done_0,
  output logic                done_1,
  output logic [width-1:0]    rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [addrsize-1:0] mem_addr,
  output logic [width-1:0]    mem_wdata,
  input  logic [width-1:0]    mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state, state_nxt;
  logic   owner;  // requester of the access in flight
  logic   last;   // most recently completed owner; the other side wins ties
  logic   win;

`ifdef ARB_LOCK_EN
  localparam int CW = $clog2(max_lock + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(max_lock);

  logic          hold;
  logic [CW-1:0] lock_cnt;
  logic          lock_ok;

  // Locked owner keeps the port until it has taken max_lock locked grants in a row.
  assign lock_ok = hold && (owner ? req_1 : req_0) && (lock_cnt != LOCK_MAX);
`else
  logic unused_lock;
  assign unused_lock = lock_0 ^ lock_1;
`endif

  always_comb begin
    win = req_1;
    if (req_0 && req_1) win = ~last;
`ifdef ARB_LOCK_EN
    if (lock_ok) win = owner;
`endif
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_0 || req_1) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      gnt_0     <= 1'b0;
      gnt_1     <= 1'b0;
      done_0    <= 1'b0;
      done_1    <= 1'b0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= 1'b0;
      last      <= 1'b1;
`ifdef ARB_LOCK_EN
      hold      <= 1'b0;
      lock_cnt  <= '0;
`endif
    end else begin
      gnt_0  <= 1'b0;
      gnt_1  <= 1'b0;
      done_0 <= 1'b0;
      done_1 <= 1'b0;
      mem_en <= 1'b0;
      case (state)
        IDLE: if (req_0 || req_1) begin
          mem_en    <= 1'b1;
          gnt_0     <= ~win;
          gnt_1     <= win;
          owner     <= win;
          mem_we    <= win ? we_1 : we_0;
          mem_addr  <= win ? addr_1 : addr_0;
          mem_wdata <= win ? wdata_1 : wdata_0;
`ifdef ARB_LOCK_EN
          lock_cnt  <= lock_ok ? lock_cnt + 1'b1 : '0;
`endif
        end
        WAIT: begin
          // mem_we still holds the command type of the access in flight
          if (!mem_we) rdata <= mem_rdata;
          done_0 <= ~owner;
          done_1 <= owner;
          last   <= owner;
`ifdef ARB_LOCK_EN
          hold   <= owner ? lock_1 : lock_0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the processor's single external memory port between requester 0 (the core) and requester 1 (the program loader/debug DMA). Each requester issues single-word read or write commands over a req/gnt/done handshake; the arbiter registers the winning command, drives the memory port for one cycle and returns read data with a done pulse. It sits between the core/loader and the synchronous data memory.

## Interface
- `width`, 32, data bus width
- `addrsize`, 8, address bus width
- `max_lock`, 4, maximum consecutive locked grants to one requester (only used with `ARB_LOCK_EN`)

- `clk` in 1: clock, all state on rising edge
- `nrst` in 1: reset, asynchronous, active-low
- `req_0`, `req_1` in 1: access request
- `we_0`, `we_1` in 1: 1 = write, 0 = read
- `addr_0`, `addr_1` in `addrsize`: word address
- `wdata_0`, `wdata_1` in `width`: write data
- `lock_0`, `lock_1` in 1: keep ownership for the next access
- `gnt_0`, `gnt_1` out 1: one-cycle grant pulse
- `done_0`, `done_1` out 1: one-cycle completion pulse
- `rdata` out `width`: read data, valid while `done_x` is high for a read
- `mem_en` out 1: memory access strobe
- `mem_we` out 1: memory write enable
- `mem_addr` out `addrsize`: memory address
- `mem_wdata` out `width`: memory write data
- `mem_rdata` in `width`: memory read data, valid one cycle after the `mem_en` cycle

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: sample `req_0`/`req_1`. With none active, stay in IDLE. Otherwise pick a winner, latch its `we`/`addr`/`wdata` into the `mem_*` registers, set `mem_en`=1 and `gnt_<w>`=1, record owner, and go to ISSUE.
- ISSUE: the memory samples the port. Clear `mem_en` and `gnt_*`, then go to WAIT.
- WAIT: `rdata` <= `mem_rdata` on reads only; `rdata` holds its value on writes. Pulse `done_<owner>`=1, update the round-robin pointer to owner, and go to IDLE.
- Round-robin: a single requester always wins. On a tie, the requester not granted most recently wins. After reset the pointer is set so that requester 0 wins the first tie.
- Requesters hold `req` and the command stable until they see `gnt`. `req` is sampled only in IDLE. A `req` still high when IDLE is next entered counts as a new request.
- `mem_we`/`mem_addr`/`mem_wdata` hold their last value outside ISSUE. Memory must qualify them with `mem_en`.
- Reset (asynchronous, any state): state IDLE, all outputs 0, `rdata`=0, pointer reset, lock counter 0. An in-flight access is dropped with no done pulse.

## Timing
- Arbitration edge E0 (IDLE, req high). `gnt` and `mem_en` are high in the cycle after E0.
- Memory samples at E1. `done` and `rdata` are valid in the cycle after E2.
- Grant-to-done latency: 2 cycles.
- Back-to-back throughput: one access per 3 cycles, with the next grant at E3.
- No combinational path from any `req`/`addr` input to any output. All outputs are registered.

## Configuration
- `ARB_LOCK_EN` defined:
  - When an access completes with the owner's `lock` high, the owner wins the next arbitration if its `req` is high at that IDLE, regardless of the pointer.
  - A lock counter counts consecutive locked grants. At `max_lock` consecutive locked grants, the next tie goes to the other requester and the counter clears.
  - The counter also clears on any unlocked grant or a change of owner.
- `ARB_LOCK_EN` undefined: `lock_0`/`lock_1` are ignored and arbitration is pure round-robin.

## Test plan
- Read, requester 0 only: `req_0`=1, `we_0`=0, `addr_0`=0x10, with memory returning 0xDEADBEEF. Expect `gnt_0` for one cycle, `mem_en` with `mem_addr`=0x10 and `mem_we`=0 in the same cycle, then `done_0` with `rdata`=0xDEADBEEF two cycles later.
- Write, requester 1: `we_1`=1, `addr_1`=0xFF, `wdata_1`=0x12345678. Expect `mem_we`=1, `mem_addr`=0xFF and `mem_wdata`=0x12345678 for one cycle, then `done_1` with `rdata` unchanged.
- Both requests held high continuously, 6 accesses: grants alternate 0,1,0,1,0,1 starting with 0 after reset, one grant every 3 cycles.
- `ARB_LOCK_EN` defined, `max_lock`=4, both requesting, `lock_0`=1: grant order 0,0,0,0,0,1,0,… (four locked grants after the initial grant to 0, then forced handover). Without the macro: strict alternation.
- Assert `nrst` low during ISSUE: `mem_en`, `gnt_*` and `done_*` go to 0 immediately, with no done pulse afterward. After release with both `req` high, the first grant goes to requester 0.
- Idle with no `req` for 10 cycles: `mem_en`, `gnt_*` and `done_*` stay 0 and `rdata` keeps its last value.
